drc_path_arbiter: RTL and testbench
===================================

DRC_PATH_ARBITER -- requirements
Module: drc_path_arbiter

Interface
REQ-001 SHALL have parameter p_paths, default 2, number of burst-FIFO paths sharing the AXI write pusher (range 2..8).
REQ-002 SHALL have parameter p_quantum, default 4, maximum consecutive bursts granted to one path while others wait (range 1..255).
REQ-003 SHALL have port i_clk  in  1  the single clock.
REQ-004 SHALL have port i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port paths_burst_empty  in  p_paths  per-path burst FIFO empty flag.
REQ-006 SHALL have port cfg_path_en  in  p_paths  per-path enable mask.
REQ-007 SHALL have port gnt  out  p_paths  one-hot grant; all zeros when no grant is offered.
REQ-008 SHALL have port gnt_valid  out  1  grant offered to the pusher.
REQ-009 SHALL have port gnt_ready  in  1  pusher accepts the offered grant.
REQ-010 SHALL have port cmpl_valid  in  1  single-cycle pulse: burst write response taken (bvalid and bready).
REQ-011 SHALL have port cmpl_resp  in  2  AXI bresp of the completed burst.
REQ-012 SHALL have port busy  out  1  a grant is offered or a burst is active.
REQ-013 SHALL have port err_flag  out  p_paths  sticky per-path error flag.
REQ-014 SHALL have port err_clr  in  p_paths  per-path error clear.
REQ-015 SHALL have port err_cnt  out  p_paths*8  per-path error counters.

Function
REQ-016 SHALL treat path i as eligible when paths_burst_empty[i]==0 and cfg_path_en[i]==1.
REQ-017 SHALL implement states IDLE, OFFER and ACTIVE.
REQ-018 SHALL, in IDLE with any path eligible, register the selected one-hot gnt, assert gnt_valid and enter OFFER on the next edge (1-cycle latency).
REQ-019 SHALL select the last-granted path again when it is eligible and its quantum count is below p_quantum; otherwise it SHALL select the first eligible path searching upward from last-granted+1, modulo p_paths.
REQ-020 SHALL hold gnt and gnt_valid stable in OFFER until gnt_ready, even if the granted path becomes ineligible.
REQ-021 SHALL, on gnt_ready in OFFER, deassert gnt_valid, keep gnt and enter ACTIVE.
REQ-022 SHALL, on cmpl_valid in ACTIVE, clear gnt, update the quantum count (increment on the same path, set to 1 on a new path) and return to IDLE.
REQ-023 SHALL ignore cmpl_valid in IDLE and OFFER, and gnt_ready outside OFFER.
REQ-024 SHALL, on cmpl_valid with cmpl_resp[1]==1 (SLVERR or DECERR), set err_flag of the granted path.
REQ-025 SHALL give set priority over err_clr when both occur in the same cycle for a path.
REQ-026 SHALL drive busy = (state != IDLE).
REQ-027 SHALL reset the quantum count to 0 in any cycle where IDLE finds no path eligible.

Reset
REQ-028 SHALL, on i_rst_n==0 at a clock edge, force: state IDLE, gnt 0, gnt_valid 0, busy 0, err_flag 0, err_cnt 0, last-granted path index p_paths-1 (so path 0 is searched first) and quantum count 0.
REQ-029 SHALL abandon an outstanding OFFER or ACTIVE grant when reset occurs mid-operation, with no completion recorded.

Configuration
REQ-030 SHALL compile per-path 8-bit saturating error counters when DRC_ARB_ERRCNT_EN is defined: increment alongside REQ-024, hold at 255, clear to 0 on err_clr (increment wins when simultaneous).
REQ-031 SHALL drive err_cnt constant 0 and infer no counter registers when DRC_ARB_ERRCNT_EN is undefined.

Structure
REQ-032 SHALL place the state encoding, AXI bresp codes (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11) and the counter width constant in the shared package drc_pkg.
REQ-033 SHALL implement round-robin selection as the combinational sub-module drc_rr_select (inputs: eligible mask and start index; output: one-hot grant).

Verification
REQ-034 SHALL cover: p_paths=2, p_quantum=4, both paths non-empty, immediate ready and completions -> grant sequence 0,0,0,0,1,1,1,1,0.
REQ-035 SHALL cover: only path 1 eligible -> gnt=2'b10 and gnt_valid high one cycle after eligibility; gnt_valid remains high through 10 cycles with gnt_ready=0.
REQ-036 SHALL cover: path 0 disabled via cfg_path_en=2'b10 while non-empty -> path 0 is never granted.
REQ-037 SHALL cover: completion on path 1 with cmpl_resp=2'b10 -> err_flag=2'b10 and err_cnt[15:8]=1 (macro defined); err_clr[1] asserted in the same cycle as a second error -> err_flag[1] remains 1.
REQ-038 SHALL cover: 300 errors on path 0 -> err_cnt[7:0]=255 with the macro defined, and err_cnt=0 with it undefined.
REQ-039 SHALL cover: i_rst_n=0 while in ACTIVE -> the next cycle has gnt=0, busy=0 and state IDLE, and a stray cmpl_valid has no effect.

Source files
------------

// File: rtl/drc_pkg.sv
// Shared definitions for the DRC path arbiter: FSM encoding, AXI bresp codes
// and the per-path error-counter width.
package drc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_ACTIVE = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int                   ERRCNT_W   = 8;
  localparam logic [ERRCNT_W-1:0]  ERRCNT_MAX = '1;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/drc_rr_select.sv
// Combinational round-robin picker: first set bit of the eligible mask found
// searching upward from the start index, wrapping modulo p_paths.
module drc_rr_select #(
  parameter int p_paths = 2,
  parameter int p_idx_w = $clog2(p_paths)
) (
  input  logic [p_paths-1:0] elig,
  input  logic [p_idx_w-1:0] start,
  output logic [p_paths-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < p_paths; k++) begin
      idx = int'(start) + k;
      if (idx >= p_paths) idx = idx - p_paths;
      if (!found && elig[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drc_path_arbiter.sv
// Quantum round-robin arbiter granting burst-FIFO paths to one AXI write pusher.
// Optional per-path saturating error counters: define DRC_ARB_ERRCNT_EN.
module drc_path_arbiter
  import drc_pkg::*;
#(
  parameter int p_paths   = 2,
  parameter int p_quantum = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [p_paths-1:0]           paths_burst_empty,
  input  logic [p_paths-1:0]           cfg_path_en,
  output logic [p_paths-1:0]           gnt,
  output logic                         gnt_valid,
  input  logic                         gnt_ready,
  input  logic                         cmpl_valid,
  input  logic [1:0]                   cmpl_resp,
  output logic                         busy,
  output logic [p_paths-1:0]           err_flag,
  input  logic [p_paths-1:0]           err_clr,
  output logic [p_paths*ERRCNT_W-1:0]  err_cnt
);

  localparam int         IW        = $clog2(p_paths);
  localparam logic [7:0] QUANT_MAX = 8'(p_quantum);

  arb_state_e           state_q, state_d;
  logic [p_paths-1:0]   gnt_q, gnt_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]        last_q, last_d;
  logic [7:0]           quant_q, quant_d;
  logic [p_paths-1:0]   err_flag_q, err_flag_d;

  logic [p_paths-1:0]   eligible;
  logic [IW-1:0]        rr_start;
  logic [p_paths-1:0]   rr_gnt;
  logic [p_paths-1:0]   last_oh;
  logic                 hold_last;
  logic [p_paths-1:0]   sel_gnt;
  logic [IW-1:0]        gnt_idx;
  logic [p_paths-1:0]   err_set;

  function automatic logic [IW-1:0] oh2idx(input logic [p_paths-1:0] oh);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < p_paths; i++) begin
      if (oh[i]) r = r | IW'(i);
    end
    return r;
  endfunction

  assign eligible = ~paths_burst_empty & cfg_path_en;
  assign rr_start = (last_q == IW'(p_paths - 1)) ? '0 : last_q + IW'(1);
  assign last_oh  = {{(p_paths-1){1'b0}}, 1'b1} << last_q;

  // A zero quantum count means no path currently owns a quantum, so the search
  // restarts after last-granted (this is what makes path 0 first out of reset).
  assign hold_last = eligible[last_q] && (quant_q != 8'd0) && (quant_q < QUANT_MAX);
  assign sel_gnt   = hold_last ? last_oh : rr_gnt;
  assign gnt_idx   = oh2idx(gnt_q);

  drc_rr_select #(
    .p_paths (p_paths),
    .p_idx_w (IW)
  ) u_rr_select (
    .elig  (eligible),
    .start (rr_start),
    .gnt   (rr_gnt)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    last_d      = last_q;
    quant_d     = quant_q;
    err_set     = '0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          gnt_d       = sel_gnt;
          gnt_valid_d = 1'b1;
          state_d     = ST_OFFER;
        end else begin
          quant_d = 8'd0;
        end
      end
      ST_OFFER: begin
        if (gnt_ready) begin
          gnt_valid_d = 1'b0;
          state_d     = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cmpl_valid) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
          last_d  = gnt_idx;
          if (gnt_idx == last_q) begin
            quant_d = (quant_q == 8'hFF) ? 8'hFF : quant_q + 8'd1;
          end else begin
            quant_d = 8'd1;
          end
          if (resp_is_err(cmpl_resp)) err_set = gnt_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
    err_flag_d = (err_flag_q & ~err_clr) | err_set;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      last_q      <= IW'(p_paths - 1);
      quant_q     <= 8'd0;
      err_flag_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      last_q      <= last_d;
      quant_q     <= quant_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_flag  = err_flag_q;

`ifdef DRC_ARB_ERRCNT_EN
  logic [p_paths-1:0][ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  // An increment in the same cycle as a clear wins; counters stick at max.
  always_comb begin
    err_cnt_d = err_cnt_q;
    for (int i = 0; i < p_paths; i++) begin
      if (err_set[i]) begin
        if (err_cnt_q[i] != ERRCNT_MAX) err_cnt_d[i] = err_cnt_q[i] + 1'b1;
      end else if (err_clr[i]) begin
        err_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_drc_path_arbiter.sv
// Self-checking bench for drc_path_arbiter: table-driven grant sequences with a
// grant scoreboard, plus hand-written offer-hold, reset and error sequences.
module tb_drc_path_arbiter;

`ifdef DRC_ARB_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        i_clk;
  logic        i_rst_n;
  logic [1:0]  paths_burst_empty;
  logic [1:0]  cfg_path_en;
  logic [1:0]  gnt;
  logic        gnt_valid;
  logic        gnt_ready;
  logic        cmpl_valid;
  logic [1:0]  cmpl_resp;
  logic        busy;
  logic [1:0]  err_flag;
  logic [1:0]  err_clr;
  logic [15:0] err_cnt;

  int n_chk;
  int n_err;

  logic [1:0] sb_q[$];

  typedef struct {
    logic [1:0] empty;
    logic [1:0] en;
    logic [1:0] resp;
    logic [1:0] exp_gnt;
    logic [1:0] exp_flag;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  drc_path_arbiter #(
    .p_paths   (2),
    .p_quantum (4)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .paths_burst_empty (paths_burst_empty),
    .cfg_path_en       (cfg_path_en),
    .gnt               (gnt),
    .gnt_valid         (gnt_valid),
    .gnt_ready         (gnt_ready),
    .cmpl_valid        (cmpl_valid),
    .cmpl_resp         (cmpl_resp),
    .busy              (busy),
    .err_flag          (err_flag),
    .err_clr           (err_clr),
    .err_cnt           (err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_in(input logic [1:0] empty, input logic [1:0] en, input logic [1:0] exp_gnt,
                          input bit push);
    paths_burst_empty = empty;
    cfg_path_en       = en;
    if (push) sb_q.push_back(exp_gnt);
  endtask

  // One full handshake: wait for an offer, score the grant, accept it, then
  // complete it while presenting the next inputs.
  task automatic txn(input logic [1:0] resp, input logic [1:0] clr,
                     input logic [1:0] nxt_empty, input logic [1:0] nxt_en);
    int         w;
    logic [1:0] exp;
    w = 0;
    @(negedge i_clk);
    while (!gnt_valid && w < 20) begin
      @(negedge i_clk);
      w++;
    end
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
      exp = 2'b00;
    end else begin
      exp = sb_q.pop_front();
    end
    if (!gnt_valid) begin
      chk("gnt_valid_timeout", 32'd0, 32'd1);
      return;
    end
    chk("gnt_offer", 32'(gnt), 32'(exp));
    tick();
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    @(negedge i_clk);
    chk("active_valid_low", 32'(gnt_valid), 32'd0);
    chk("active_gnt_kept", 32'(gnt), 32'(exp));
    tick();
    paths_burst_empty = nxt_empty;
    cfg_path_en       = nxt_en;
    cmpl_valid        = 1'b1;
    cmpl_resp         = resp;
    err_clr           = clr;
    tick();
    cmpl_valid = 1'b0;
    cmpl_resp  = 2'b00;
    err_clr    = 2'b00;
    @(negedge i_clk);
    chk("cmpl_gnt_clear", 32'(gnt), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    i_rst_n           = 1'b0;
    paths_burst_empty = 2'b11;
    cfg_path_en       = 2'b00;
    gnt_ready         = 1'b0;
    cmpl_valid        = 1'b0;
    cmpl_resp         = 2'b00;
    err_clr           = 2'b00;

    for (int i = 0; i < 9; i++) begin
      tbl[i] = '{2'b00, 2'b11, 2'b00, (i < 4 || i == 8) ? 2'b01 : 2'b10, 2'b00};
    end
    for (int i = 9; i < 12; i++) tbl[i] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    for (int i = 12; i < 14; i++) tbl[i] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00};
    tbl[14] = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
    tbl[15] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b10};
    tbl[16] = '{2'b01, 2'b11, 2'b01, 2'b10, 2'b10};

    repeat (3) tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Table: quantum rotation, disabled path, empty paths, error responses.
    tick();
    drive_in(tbl[0].empty, tbl[0].en, tbl[0].exp_gnt, 1'b1);
    for (int r = 0; r < NV; r++) begin
      if (r + 1 < NV) begin
        sb_q.push_back(tbl[r+1].exp_gnt);
        txn(tbl[r].resp, 2'b00, tbl[r+1].empty, tbl[r+1].en);
      end else begin
        txn(tbl[r].resp, 2'b00, 2'b11, 2'b11);
      end
      chk($sformatf("row%0d_err_flag", r), 32'(err_flag), 32'(tbl[r].exp_flag));
      if (r == 14) chk("row14_err_cnt1", 32'(err_cnt[15:8]), CNT_EN ? 32'd1 : 32'd0);
    end
    chk("tbl_err_cnt0", 32'(err_cnt[7:0]), 32'd0);

    // Error set and clear in the same cycle on path 1: set must win.
    tick();
    drive_in(2'b01, 2'b11, 2'b10, 1'b1);
    txn(2'b10, 2'b10, 2'b11, 2'b11);
    chk("setclr_flag", 32'(err_flag), 32'h2);
    chk("setclr_cnt1", 32'(err_cnt[15:8]), CNT_EN ? 32'd3 : 32'd0);
    tick();
    err_clr = 2'b10;
    tick();
    err_clr = 2'b00;
    @(negedge i_clk);
    chk("clr_flag", 32'(err_flag), 32'd0);
    chk("clr_cnt1", 32'(err_cnt[15:8]), 32'd0);

    // Offer latency and hold while ready is low, even after the path goes empty.
    tick();
    paths_burst_empty = 2'b01;
    cfg_path_en       = 2'b11;
    @(negedge i_clk);
    chk("offer_latency_0", 32'(gnt_valid), 32'd0);
    @(negedge i_clk);
    chk("offer_valid", 32'(gnt_valid), 32'd1);
    chk("offer_gnt", 32'(gnt), 32'h2);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 3) paths_burst_empty = 2'b11;
      cmpl_valid = (c == 5);
      cmpl_resp  = (c == 5) ? 2'b11 : 2'b00;
      @(negedge i_clk);
      chk($sformatf("hold%0d", c), {29'd0, gnt_valid, gnt}, {29'd0, 1'b1, 2'b10});
    end
    tick();
    cmpl_valid = 1'b0;
    cmpl_resp  = 2'b00;
    chk("offer_cmpl_ignored", 32'(err_flag), 32'd0);
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    @(negedge i_clk);
    chk("active_state", {30'd0, busy, gnt_valid}, 32'h2);

    // Reset while ACTIVE, with a stray completion in the reset cycle and after.
    tick();
    i_rst_n    = 1'b0;
    cmpl_valid = 1'b1;
    cmpl_resp  = 2'b10;
    tick();
    i_rst_n    = 1'b1;
    cmpl_valid = 1'b0;
    cmpl_resp  = 2'b00;
    @(negedge i_clk);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err_flag), 32'd0);
    tick();
    cmpl_valid = 1'b1;
    cmpl_resp  = 2'b11;
    gnt_ready  = 1'b1;
    tick();
    cmpl_valid = 1'b0;
    cmpl_resp  = 2'b00;
    gnt_ready  = 1'b0;
    @(negedge i_clk);
    chk("stray_err", 32'(err_flag), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_cnt", 32'(err_cnt), 32'd0);

    // 300 errors on path 0: counter saturates at 255.
    tick();
    drive_in(2'b10, 2'b11, 2'b01, 1'b1);
    for (int n = 0; n < 300; n++) begin
      if (n < 299) begin
        sb_q.push_back(2'b01);
        txn(2'b10, 2'b00, 2'b10, 2'b11);
      end else begin
        txn(2'b10, 2'b00, 2'b11, 2'b11);
      end
    end
    chk("sat_flag", 32'(err_flag), 32'h1);
    chk("sat_cnt0", 32'(err_cnt[7:0]), CNT_EN ? 32'd255 : 32'd0);
    chk("sat_cnt1", 32'(err_cnt[15:8]), 32'd0);
    tick();
    err_clr = 2'b01;
    tick();
    err_clr = 2'b00;
    @(negedge i_clk);
    chk("sat_clr_cnt0", 32'(err_cnt), 32'd0);
    chk("sat_clr_flag", 32'(err_flag), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
